// File: rtl/control_unit.sv
// Multicycle Moore sequencer for the K&S processor: drives the data_path strobes,
// RAM write and halt from a registered state, with optional RAM wait cycles.
package control_unit_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_LOAD_ADDR = 4'd2,
        S_LOAD_WB   = 4'd3,
        S_STORE     = 4'd4,
        S_ALU       = 4'd5,
        S_BRANCH    = 4'd6,
        S_NEXT      = 4'd7,
        S_HALT      = 4'd8
    } state_t;

    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       addr_sel;
        logic       c_sel;
        logic [1:0] operation;
        logic       write_reg_enable;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic       halt;
    } ctrl_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       started_q, started_d;
    ctrl_t      ctrl_q, ctrl_d;

    // The carry flag is not consulted by any branch condition.
    logic unused_s;
    assign unused_s = unsigned_overflow;

    function automatic state_t decode_next(decoded_instruction_type ins, logic z, logic n, logic v);
        state_t nxt;
        case (ins)
            I_LOAD:                              nxt = S_LOAD_ADDR;
            I_STORE:                             nxt = S_STORE;
            I_ADD, I_SUB, I_AND, I_OR, I_MOVE:   nxt = S_ALU;
            I_BRANCH:                            nxt = S_BRANCH;
            I_BZERO:                             nxt = z  ? S_BRANCH : S_NEXT;
            I_BNZERO:                            nxt = !z ? S_BRANCH : S_NEXT;
            I_BNEG:                              nxt = n  ? S_BRANCH : S_NEXT;
            I_BNNEG:                             nxt = !n ? S_BRANCH : S_NEXT;
            I_BOV:                               nxt = v  ? S_BRANCH : S_NEXT;
            I_BNOV:                              nxt = !v ? S_BRANCH : S_NEXT;
            I_HALT:                              nxt = S_HALT;
            default:                             nxt = S_NEXT;
        endcase
        return nxt;
    endfunction

    // The ALU state is only ever entered straight from DECODE, so the live
    // instruction is still the one being executed when its strobes are computed.
    function automatic ctrl_t decode_ctrl(state_t st, logic [2:0] wt, decoded_instruction_type ins);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:     c.ir_enable = (wt == WAIT_LAST);
            S_LOAD_ADDR: c.addr_sel  = 1'b1;
            S_LOAD_WB: begin
                c.addr_sel         = 1'b1;
                c.c_sel            = 1'b1;
                c.write_reg_enable = 1'b1;
                c.pc_enable        = 1'b1;
            end
            S_STORE: begin
                c.addr_sel         = 1'b1;
                c.ram_write_enable = 1'b1;
                c.pc_enable        = 1'b1;
            end
            S_ALU: begin
                c.write_reg_enable = 1'b1;
                c.pc_enable        = 1'b1;
                case (ins)
                    I_ADD:   begin c.operation = 2'b00; c.flags_reg_enable = 1'b1; end
                    I_SUB:   begin c.operation = 2'b01; c.flags_reg_enable = 1'b1; end
                    I_AND:   begin c.operation = 2'b10; c.flags_reg_enable = 1'b1; end
                    I_OR:    begin c.operation = 2'b11; c.flags_reg_enable = 1'b1; end
                    I_MOVE:  begin c.operation = 2'b11; c.flags_reg_enable = 1'b0; end
                    default: begin c.operation = 2'b00; c.flags_reg_enable = 1'b0; end
                endcase
            end
            S_BRANCH: begin
                c.branch    = 1'b1;
                c.pc_enable = 1'b1;
            end
            S_NEXT:  c.pc_enable = 1'b1;
            S_HALT:  c.halt      = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state, wait counter and the strobes that the next state will present.
    always_comb begin
        state_d   = state_q;
        wait_d    = 3'd0;
        started_d = 1'b1;
        if (!started_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH, S_LOAD_ADDR: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = (state_q == S_FETCH) ? S_DECODE : S_LOAD_WB;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
                S_DECODE: state_d = decode_next(decoded_instruction, zero_op, neg_op, signed_overflow);
                S_LOAD_WB, S_STORE, S_ALU, S_BRANCH, S_NEXT: state_d = S_FETCH;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_FETCH;
            endcase
        end
        ctrl_d = decode_ctrl(state_d, wait_d, decoded_instruction);
    end

    // State, wait counter and output strobes; reset clears every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 3'd0;
            started_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            started_q <= started_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign branch           = ctrl_q.branch;
    assign pc_enable        = ctrl_q.pc_enable;
    assign ir_enable        = ctrl_q.ir_enable;
    assign addr_sel         = ctrl_q.addr_sel;
    assign c_sel            = ctrl_q.c_sel;
    assign operation        = ctrl_q.operation;
    assign write_reg_enable = ctrl_q.write_reg_enable;
    assign flags_reg_enable = ctrl_q.flags_reg_enable;
    assign ram_write_enable = ctrl_q.ram_write_enable;
    assign halt             = ctrl_q.halt;

endmodule
